// File: rtl/proc_sequencer.sv
// ----------------------------------------------------------------------------
// proc_sequencer : fetch/decode/execute controller with PC, flags and retire count
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module proc_sequencer #(
  parameter int AW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   ir_out,
  output logic          exec_en,
  input  logic [3:0]    flags_in,
  output logic [3:0]    flags_q,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_NEXT   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   ir_q, ir_d;
  logic [3:0]    flags_d;
  logic [CW-1:0] retired_q, retired_d;

  logic [4:0]    opcode;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_inc;
  logic          is_alu;
  logic          is_halt;
  logic          take_jump;
  logic          f_sign, f_zero, f_ovf, f_carry;

  assign opcode  = ir_q[31:27];
  assign target  = ir_q[AW-1:0];
  assign pc_inc  = pc_q + AW'(1);
  assign is_alu  = (opcode <= 5'd11);
  assign is_halt = (opcode == 5'b10101);
  assign {f_sign, f_zero, f_ovf, f_carry} = flags_q;

  // Branch resolution always uses the flags of the most recent ALU commit.
  always_comb begin
    take_jump = 1'b0;
    case (opcode)
      5'b01100: take_jump = 1'b1;
      5'b01101: take_jump = f_carry;
      5'b01110: take_jump = ~f_carry;
      5'b01111: take_jump = f_sign;
      5'b10000: take_jump = ~f_sign;
      5'b10001: take_jump = f_zero;
      5'b10010: take_jump = ~f_zero;
      5'b10011: take_jump = f_ovf;
      5'b10100: take_jump = ~f_ovf;
      default:  take_jump = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          retired_d = '0;
          flags_d   = '0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = is_alu ? S_EXEC : S_NEXT;
      S_EXEC: begin
        flags_d = flags_in;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        retired_d = retired_q + CW'(1);
        if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = take_jump ? target : pc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  // Strobes decode straight from state so an async reset clears them at once.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign ir_out    = ir_q;
  assign exec_en   = (state_q == S_EXEC);
  assign pc        = pc_q;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXEC)  || (state_q == S_NEXT);
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

endmodule

`default_nettype wire
